// File: rtl/ps2_host_tx_pkg.sv
// Shared SPAM bus widths, keyboard-controller device id, host-tx FSM states and
// status register bit positions for the PS/2 host-to-device command path.
package ps2_host_tx_pkg;

  localparam int SPAM_DID_HI  = 3;
  localparam int SPAM_ADDR_HI = 23;
  localparam int SPAM_DATA_HI = 31;

  localparam logic [SPAM_DID_HI:0] SPAM_DID_KBDCTL = 4'h5;

  // Status read word layout; every bit above ST_OVR reads as zero.
  localparam int ST_CMD_LSB = 0;
  localparam int ST_BUSY    = 8;
  localparam int ST_ACKED   = 9;
  localparam int ST_ERR     = 10;
  localparam int ST_OVR     = 11;

  // Falls seen in SHIFT are numbered from 1; the last one releases data (stop).
  localparam logic [3:0] LAST_SHIFT = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_RTS     = 3'd2,
    S_SHIFT   = 3'd3,
    S_ACK     = 3'd4,
    S_WAITHI  = 3'd5
  } tx_state_e;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_pin_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins, plus a registered
// one-cycle pulse marking each synchronized 1->0 edge of the clock.
module ps2_pin_sync (
  input  logic cclk,
  input  logic cclk_rst_b,
  input  logic ps2clk,
  input  logic ps2data,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       fall_q;

  // Lines idle high, so reset to 1 to avoid a phantom edge on release.
  always_ff @(posedge cclk or negedge cclk_rst_b) begin
    if (!cclk_rst_b) begin
      clk_ff  <= 2'b11;
      data_ff <= 2'b11;
      fall_q  <= 1'b0;
    end else begin
      clk_ff  <= {clk_ff[0], ps2clk};
      data_ff <= {data_ff[0], ps2data};
      fall_q  <= clk_ff[1] & ~clk_ff[0];
    end
  end

  assign clk_s    = clk_ff[1];
  assign data_s   = data_ff[1];
  assign clk_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: takes a command byte over SPAM, inhibits
// the bus, requests to send, shifts the frame out on device clocks, checks ack.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter logic [SPAM_ADDR_HI:0] SPAM_ADDRPFX  = 24'h000000,
  parameter logic [SPAM_ADDR_HI:0] SPAM_ADDRMASK = 24'h000000,
  parameter int                    INHIBIT_CYCLES = 5000,
  parameter int                    TIMEOUT_CYCLES = 750000
) (
  input  logic                    cclk,
  input  logic                    cclk_rst_b,
  input  logic                    spamo_valid,
  input  logic                    spamo_r_nw,
  input  logic [SPAM_DID_HI:0]    spamo_did,
  input  logic [SPAM_ADDR_HI:0]   spamo_addr,
  input  logic [SPAM_DATA_HI:0]   spamo_data,
  input  logic                    ps2clk,
  input  logic                    ps2data,
  output logic                    ps2clk_low,
  output logic                    ps2data_low,
  output logic                    tx_active,
  output logic                    ps2tx__spami_busy_b,
  output logic [SPAM_DATA_HI:0]   ps2tx__spami_data
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_s, data_s, clk_fall;

  ps2_pin_sync u_sync (
    .cclk       (cclk),
    .cclk_rst_b (cclk_rst_b),
    .ps2clk     (ps2clk),
    .ps2data    (ps2data),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fall   (clk_fall)
  );

  // SPAM handshake: a request is one cycle of spamo_valid with did/addr/data
  // stable in that cycle; each decoded request gets exactly one response cycle
  // on the next cycle with busy_b=1 and data = status (read) or 0 (write).
  // Outside a response cycle busy_b and data are both 0.
  logic spam_hit, rd_hit, wr_hit, wr_accept;
  logic unused_data;

  assign spam_hit  = spamo_valid && (spamo_did == SPAM_DID_KBDCTL) &&
                     ((spamo_addr & SPAM_ADDRMASK) == SPAM_ADDRPFX);
  assign rd_hit    = spam_hit && spamo_r_nw;
  assign wr_hit    = spam_hit && !spamo_r_nw;
  assign unused_data = ^spamo_data[SPAM_DATA_HI:8];

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [8:0]        frame_q;
  logic [7:0]        cmd_q;
  logic              acked_q, err_q, ovr_q;
  logic              shift_en, ack_evt, err_evt, tmo_hit;

  assign wr_accept = wr_hit && (state_q == S_IDLE);
  assign tmo_hit   = (cnt_q == TMO_LAST);

  // cnt_q times INHIBIT and, in the device-clocked states, the gap since the
  // last falling clock edge; each fall reloads it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_en  = 1'b0;
    ack_evt   = 1'b0;
    err_evt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_accept) begin
          state_d   = S_INHIBIT;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = S_RTS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RTS: begin
        if (clk_fall) begin
          state_d   = S_SHIFT;
          bit_cnt_d = 4'd1;
          cnt_d     = '0;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (bit_cnt_q == LAST_SHIFT) begin
            state_d = S_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_en  = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        if (clk_fall) begin
          cnt_d   = '0;
          state_d = S_WAITHI;
          if (data_s) err_evt = 1'b1;
          else        ack_evt = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAITHI: begin
        if (clk_s && data_s) begin
          state_d = S_IDLE;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cclk or negedge cclk_rst_b) begin
    if (!cclk_rst_b) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // frame_q[0] is the bit currently presented; it holds {parity, cmd} at load.
  always_ff @(posedge cclk or negedge cclk_rst_b) begin
    if (!cclk_rst_b) begin
      cmd_q   <= '0;
      frame_q <= '0;
      acked_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (wr_accept) begin
        cmd_q   <= spamo_data[7:0];
        frame_q <= {odd_parity(spamo_data[7:0]), spamo_data[7:0]};
      end else if (shift_en) begin
        frame_q <= {1'b0, frame_q[8:1]};
      end
      acked_q <= ack_evt | (acked_q & ~wr_accept);
      // A read samples the old flags; an error raised in that same cycle survives.
      err_q   <= err_evt | (err_q & ~rd_hit);
      ovr_q   <= (wr_hit & ~wr_accept) | (ovr_q & ~rd_hit);
    end
  end

  logic [SPAM_DATA_HI:0] status;

  always_comb begin
    status                          = '0;
    status[ST_CMD_LSB +: 8]         = cmd_q;
    status[ST_BUSY]                 = (state_q != S_IDLE);
    status[ST_ACKED]                = acked_q;
    status[ST_ERR]                  = err_q;
    status[ST_OVR]                  = ovr_q;
  end

  always_ff @(posedge cclk or negedge cclk_rst_b) begin
    if (!cclk_rst_b) begin
      ps2tx__spami_busy_b <= 1'b0;
      ps2tx__spami_data   <= '0;
    end else begin
      ps2tx__spami_busy_b <= spam_hit;
      ps2tx__spami_data   <= rd_hit ? status : '0;
    end
  end

  always_comb begin
    ps2clk_low  = 1'b0;
    ps2data_low = 1'b0;
    case (state_q)
      S_INHIBIT: ps2clk_low  = 1'b1;
      S_RTS:     ps2data_low = 1'b1;
      S_SHIFT:   ps2data_low = ~frame_q[0];
      default:   ;
    endcase
  end

  assign tx_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device-side PS/2 model on open-drain pins, SPAM
// read/write driver, table vectors, multi-cycle corner sequences, random cmds.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 300;
  localparam int H   = 8;
  localparam logic [23:0] PFX      = 24'h001000;
  localparam logic [23:0] MASK     = 24'hFFFFF0;
  localparam logic [23:0] ADDR_OK  = 24'h001004;
  localparam logic [23:0] ADDR_BAD = 24'h002004;
  localparam logic [3:0]  DID_BAD  = 4'hA;

  logic        cclk = 1'b0;
  logic        cclk_rst_b = 1'b0;
  logic        spamo_valid = 1'b0;
  logic        spamo_r_nw = 1'b0;
  logic [3:0]  spamo_did = '0;
  logic [23:0] spamo_addr = '0;
  logic [31:0] spamo_data = '0;
  logic        ps2clk, ps2data;
  logic        ps2clk_low, ps2data_low, tx_active;
  logic        ps2tx__spami_busy_b;
  logic [31:0] ps2tx__spami_data;
  logic        dev_clk = 1'b1;
  logic        dev_data = 1'b1;

  assign ps2clk  = dev_clk & ~ps2clk_low;
  assign ps2data = dev_data & ~ps2data_low;

  ps2_host_tx #(
    .SPAM_ADDRPFX   (PFX),
    .SPAM_ADDRMASK  (MASK),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .cclk                (cclk),
    .cclk_rst_b          (cclk_rst_b),
    .spamo_valid         (spamo_valid),
    .spamo_r_nw          (spamo_r_nw),
    .spamo_did           (spamo_did),
    .spamo_addr          (spamo_addr),
    .spamo_data          (spamo_data),
    .ps2clk              (ps2clk),
    .ps2data             (ps2data),
    .ps2clk_low          (ps2clk_low),
    .ps2data_low         (ps2data_low),
    .tx_active           (tx_active),
    .ps2tx__spami_busy_b (ps2tx__spami_busy_b),
    .ps2tx__spami_data   (ps2tx__spami_data)
  );

  // ---------------- clock / watchdog ----------------
  always #5 cclk = ~cclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [7:0] m_cmd;
  logic       m_acked, m_err, m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cmd = '0; m_acked = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] c, input bit idle);
    if (idle) begin m_cmd = c; m_acked = 1'b0; end
    else m_ovr = 1'b1;
  endtask

  task automatic model_read(input bit busy, output logic [31:0] st);
    st = {20'd0, m_ovr, m_err, m_acked, busy, m_cmd};
    m_err = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_done(input bit ack_low);
    if (ack_low) m_acked = 1'b1;
    else m_err = 1'b1;
  endtask

  // Wire order on the bus: 8 data bits LSB first, odd parity, stop (released high).
  function automatic logic [9:0] exp_frame(input logic [7:0] c);
    logic par;
    par = ($countones(c) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic spam_op(input logic r_nw, input logic [3:0] did, input logic [23:0] addr,
                         input logic [31:0] wdata, output logic busy_b, output logic [31:0] rdata);
    @(negedge cclk);
    spamo_valid = 1'b1;
    spamo_r_nw  = r_nw;
    spamo_did   = did;
    spamo_addr  = addr;
    spamo_data  = wdata;
    @(negedge cclk);
    spamo_valid = 1'b0;
    busy_b = ps2tx__spami_busy_b;
    rdata  = ps2tx__spami_data;
  endtask

  task automatic spam_read(output logic [31:0] rdata);
    logic bb;
    spam_op(1'b1, SPAM_DID_KBDCTL, ADDR_OK, 32'd0, bb, rdata);
    check("read_busy_b", {31'd0, bb}, 32'd1);
  endtask

  task automatic spam_write(input logic [7:0] c);
    logic bb;
    logic [31:0] rd;
    spam_op(1'b0, SPAM_DID_KBDCTL, ADDR_OK, {$urandom_range(0, 255), 16'h0000, c}, bb, rd);
    check("write_resp", {rd[30:0], bb}, 32'd1);
  endtask

  task automatic wait_rts(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < INH + 20; i++) begin
      if (!ps2clk_low && tx_active) begin seen = 1'b1; break; end
      @(negedge cclk);
    end
    check("rts_reached", {31'd0, seen}, 32'd1);
  endtask

  // Device side: waits for RTS, clocks 11 falls, samples host data on rising
  // edges, drives the ack bit before fall 11. abort_at>0 stops low after that fall.
  task automatic device_xfer(input bit ack_low, input int abort_at, output logic [9:0] bits);
    bit seen;
    bits = '0;
    seen = 1'b0;
    for (int i = 0; i < INH + 50; i++) begin
      @(negedge cclk);
      if (!ps2clk_low && ps2data_low) begin seen = 1'b1; break; end
    end
    check("dev_rts_seen", {31'd0, seen}, 32'd1);
    if (!seen) return;
    repeat (H) @(negedge cclk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == abort_at) begin
        repeat (H / 2) @(negedge cclk);
        return;
      end
      repeat (H) @(negedge cclk);
      dev_clk = 1'b1;
      if (k <= 10) bits[k-1] = ps2data;
      if (k == 10) dev_data = ~ack_low;
      if (k == 11) dev_data = 1'b1;
      repeat (H) @(negedge cclk);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  cmd;
    bit          ack_low;
    logic [31:0] exp_busy;
    logic [9:0]  exp_frm;
    logic [31:0] exp_st1;
    logic [31:0] exp_st2;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] rd, st;
    logic [9:0]  frm;
    logic        bb;
    bit          seen, early;
    logic [7:0]  c;
    bit          al;

    vecs[0] = '{cmd: 8'hED, ack_low: 1'b1, exp_busy: 32'h1ED, exp_frm: 10'h3ED, exp_st1: 32'h2ED, exp_st2: 32'h2ED};
    vecs[1] = '{cmd: 8'hF4, ack_low: 1'b0, exp_busy: 32'h1F4, exp_frm: 10'h2F4, exp_st1: 32'h4F4, exp_st2: 32'h0F4};
    vecs[2] = '{cmd: 8'h00, ack_low: 1'b1, exp_busy: 32'h100, exp_frm: 10'h300, exp_st1: 32'h200, exp_st2: 32'h200};
    vecs[3] = '{cmd: 8'h81, ack_low: 1'b0, exp_busy: 32'h181, exp_frm: 10'h381, exp_st1: 32'h481, exp_st2: 32'h081};

    // reset state
    model_reset();
    #2;
    check("rst_clk_low",  {31'd0, ps2clk_low}, 32'd0);
    check("rst_data_low", {31'd0, ps2data_low}, 32'd0);
    check("rst_tx_active", {31'd0, tx_active}, 32'd0);
    check("rst_busy_b", {31'd0, ps2tx__spami_busy_b}, 32'd0);
    check("rst_rdata", ps2tx__spami_data, 32'd0);
    repeat (3) @(negedge cclk);
    cclk_rst_b = 1'b1;
    repeat (3) @(negedge cclk);

    // table vectors
    for (int v = 0; v < 4; v++) begin
      spam_write(vecs[v].cmd);
      model_write(vecs[v].cmd, 1'b1);
      spam_read(rd);
      model_read(1'b1, st);
      check("tbl_busy_status", rd, vecs[v].exp_busy);
      device_xfer(vecs[v].ack_low, 0, frm);
      model_done(vecs[v].ack_low);
      check("tbl_frame", {22'd0, frm}, {22'd0, vecs[v].exp_frm});
      check("tbl_tx_idle", {31'd0, tx_active}, 32'd0);
      spam_read(rd);
      model_read(1'b0, st);
      check("tbl_status1", rd, vecs[v].exp_st1);
      spam_read(rd);
      model_read(1'b0, st);
      check("tbl_status2", rd, vecs[v].exp_st2);
    end

    // inhibit width, then a second write while the first is in flight
    spam_write(8'h55);
    model_write(8'h55, 1'b1);
    begin
      int n;
      n = 0;
      while (ps2clk_low && n < INH + 10) begin n++; @(negedge cclk); end
      check("inhibit_width", n, INH);
    end
    check("rts_data_low", {31'd0, ps2data_low}, 32'd1);
    spam_write(8'hAA);
    model_write(8'hAA, 1'b0);
    device_xfer(1'b1, 0, frm);
    model_done(1'b1);
    check("ovr_frame_first_cmd", {22'd0, frm}, {22'd0, exp_frame(8'h55)});
    spam_read(rd);
    model_read(1'b0, st);
    check("ovr_status_set", rd, st);
    check("ovr_status_const", rd, 32'hA55);
    spam_read(rd);
    model_read(1'b0, st);
    check("ovr_status_cleared", rd, 32'h255);

    // device never clocks: timeout exactly TMO cycles after RTS entry,
    // with a read landing in the same cycle as the error
    spam_write(8'h3C);
    model_write(8'h3C, 1'b1);
    wait_rts(seen);
    early = 1'b0;
    for (int i = 1; i < TMO - 1; i++) begin
      @(negedge cclk);
      if (!tx_active) early = 1'b1;
    end
    check("tmo_not_early", {31'd0, early}, 32'd0);
    spam_op(1'b1, SPAM_DID_KBDCTL, ADDR_OK, 32'd0, bb, rd);
    model_read(1'b1, st);
    m_err = 1'b1;
    check("tmo_same_cycle_read_old", rd, st);
    check("tmo_released", {29'd0, tx_active, ps2clk_low, ps2data_low}, 32'd0);
    spam_read(rd);
    model_read(1'b0, st);
    check("tmo_err_survives", rd, 32'h43C);
    spam_read(rd);
    model_read(1'b0, st);
    check("tmo_err_cleared", rd, 32'h03C);

    // asynchronous reset in the middle of the shift phase
    spam_write(8'h96);
    model_write(8'h96, 1'b1);
    device_xfer(1'b1, 4, frm);
    check("abort_mid_shift_active", {31'd0, tx_active}, 32'd1);
    #1 cclk_rst_b = 1'b0;
    #1;
    check("abort_outputs_zero",
          {27'd0, ps2clk_low, ps2data_low, tx_active, ps2tx__spami_busy_b, |ps2tx__spami_data}, 32'd0);
    dev_clk = 1'b1;
    dev_data = 1'b1;
    model_reset();
    repeat (3) @(negedge cclk);
    cclk_rst_b = 1'b1;
    repeat (3) @(negedge cclk);
    spam_read(rd);
    model_read(1'b0, st);
    check("abort_status_zero", rd, 32'h000);
    spam_write(8'hFF);
    model_write(8'hFF, 1'b1);
    device_xfer(1'b1, 0, frm);
    model_done(1'b1);
    check("post_reset_frame", {22'd0, frm}, 32'h3FF);
    spam_read(rd);
    model_read(1'b0, st);
    check("post_reset_status", rd, 32'h2FF);

    // mismatched device id / address
    spam_op(1'b1, DID_BAD, ADDR_OK, 32'd0, bb, rd);
    check("bad_did_busy_b", {31'd0, bb}, 32'd0);
    check("bad_did_data", rd, 32'd0);
    spam_op(1'b1, SPAM_DID_KBDCTL, ADDR_BAD, 32'd0, bb, rd);
    check("bad_addr_busy_b", {31'd0, bb}, 32'd0);
    check("bad_addr_data", rd, 32'd0);
    spam_op(1'b0, DID_BAD, ADDR_OK, 32'h0000_00F0, bb, rd);
    @(negedge cclk);
    check("bad_did_write_ignored", {31'd0, tx_active}, 32'd0);

    // random commands against the model
    for (int r = 0; r < 5; r++) begin
      c  = 8'($urandom_range(0, 255));
      al = bit'($urandom_range(0, 1));
      spam_write(c);
      model_write(c, 1'b1);
      device_xfer(al, 0, frm);
      model_done(al);
      exp_q.push_back({22'd0, exp_frame(c)});
      model_read(1'b0, st);
      exp_q.push_back(st);
      check("rnd_frame", {22'd0, frm}, exp_q.pop_front());
      spam_read(rd);
      check("rnd_status", rd, exp_q.pop_front());
    end

    repeat (5) @(negedge cclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
